usb_out_ep_arbiter: RTL and testbench
=====================================

// Module: usb_out_ep_arbiter
// PURPOSE
//   Shares the USB core's single OUT-endpoint data interface among NUM_EP endpoint
//   clients, for example several usb_uart-style OUT endpoints. Each client raises
//   ep_req; the arbiter issues a registered one-hot ep_grant using round-robin order.
//   Only the granted client's data_get and stall reach the core. A grant is held
//   until the client drops ep_req. An optional idle timeout can preempt a client
//   that holds the interface without taking data.
// PARAMETERS
//   NUM_EP      4   number of clients; legal range 2..16
//   HOLD_LIMIT  0   idle-cycle preemption threshold; 0 disables preemption
//   IDX_BITS    $clog2(NUM_EP)   width of grant_idx (derived; do not override)
// PORTS
//   clk            in   1         single clock; all state changes on posedge
//   reset          in   1         asynchronous, active-low
//   ep_req         in   NUM_EP    per-client interface request
//   ep_data_get    in   NUM_EP    per-client data strobe; valid only while granted
//   ep_stall       in   NUM_EP    per-client stall; valid only while granted
//   ep_grant       out  NUM_EP    one-hot or zero grant, registered
//   grant_valid    out  1         equals |ep_grant
//   grant_idx      out  IDX_BITS  index of the granted client; 0 when grant_valid=0
//   core_data_get  out  1         ep_data_get[grant_idx] & grant_valid (combinational)
//   core_stall     out  1         ep_stall[grant_idx] & grant_valid (combinational)
// BEHAVIOUR
// - Reset (reset=0, asynchronous): ep_grant=0, grant_valid=0, grant_idx=0,
//   rr_ptr=0, idle_cnt=0, FSM=IDLE. Because core_data_get and core_stall are
//   gated by grant_valid, both read 0 during reset. Reset may arrive mid-grant;
//   the grant drops immediately with no drain.
// - FSM has two states: IDLE and GRANTED.
//   IDLE: if ep_req != 0, then at the next edge grant the first requester found by
//     searching from rr_ptr upward with wrap-around. Set rr_ptr to winner+1
//     (mod NUM_EP) and enter GRANTED. Request-to-grant latency is 1 cycle.
//   GRANTED: when ep_req[grant_idx]=0 is sampled, the next edge releases the grant.
//     In that same edge, if any other client is requesting, grant it directly
//     (searching from rr_ptr). That makes the handover 0 bubble cycles. Otherwise
//     return to IDLE.
//   A client that re-requests right after release is searched last, behind every
//     other waiting client.
// - Grant rules:
//   - ep_grant changes only on a clock edge and is never multi-hot.
//   - ep_data_get and ep_stall from ungranted clients are ignored.
// - Preemption (HOLD_LIMIT>0):
//   - idle_cnt counts consecutive GRANTED cycles with ep_data_get[grant_idx]=0.
//   - idle_cnt clears on any data_get, on any grant change, and in IDLE.
//   - When idle_cnt==HOLD_LIMIT-1 and another client requests, the next edge moves
//     the grant to that client as a normal handover. The preempted client's
//     request stays pending.
//   - Preemption never occurs in a cycle where ep_data_get[grant_idx]=1.
//   - idle_cnt saturates and never wraps.
//   - Width is $clog2(HOLD_LIMIT+1); a 1-bit dummy is used when HOLD_LIMIT=0.
// - Simultaneous events: a release and a new request in the same cycle are resolved
//   by the rr_ptr search. When release and preemption coincide, release wins
//   (same outcome, and idle_cnt clears).
// - rr_ptr arithmetic wraps modulo NUM_EP. Non-power-of-2 NUM_EP must wrap at
//   NUM_EP-1 -> 0, never through unused codes.
// TESTING (NUM_EP=4 unless noted)
// - Reset/basic:
//   - Stimulus: reset low with ep_req=4'b0100, then release reset.
//   - Required: grant 0 throughout reset; ep_grant=4'b0100 and grant_idx=2 on the
//     1st edge after reset; core_data_get follows ep_data_get[2] only.
// - Round-robin:
//   - Stimulus: ep_req=4'b1111 held, with each grantee dropping req for 1 cycle
//     after 3 cycles of data_get.
//   - Required: grant order 0,1,2,3,0, with no idle cycle between grants.
// - Isolation:
//   - Stimulus: grant on client 1; pulse ep_data_get[0] and ep_stall[3].
//   - Required: core_data_get=0 and core_stall=0. Then pulse ep_stall[1].
//   - Required: core_stall=1 in the same cycle.
// - Preemption (HOLD_LIMIT=8):
//   - Stimulus: client 0 granted and idle; client 2 requests at cycle 3.
//   - Required: grant moves to client 2 at the edge after idle_cnt reaches 7; no
//     preemption if client 0 strobes data_get every 7 cycles.
// - Mid-grant reset:
//   - Stimulus: assert reset (low) between edges while client 3 is granted.
//   - Required: ep_grant=0 immediately, asynchronously.
//   - Required after release: the search restarts at rr_ptr=0.
// - NUM_EP=3 wrap:
//   - Stimulus: ep_req=3'b111 held with single-cycle releases.
//   - Required: order 0,1,2,0,1; grant_idx never equals 3.

Source files
------------

// File: rtl/usb_out_ep_arbiter.sv
// usb_out_ep_arbiter: round-robin arbiter sharing the USB core OUT-endpoint interface
// among NUM_EP clients, with optional idle-timeout preemption of the current grantee.
module usb_out_ep_arbiter #(
    parameter int NUM_EP     = 4,
    parameter int HOLD_LIMIT = 0,
    parameter int IDX_BITS   = $clog2(NUM_EP)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_EP-1:0]   ep_req,
    input  logic [NUM_EP-1:0]   ep_data_get,
    input  logic [NUM_EP-1:0]   ep_stall,
    output logic [NUM_EP-1:0]   ep_grant,
    output logic                grant_valid,
    output logic [IDX_BITS-1:0] grant_idx,
    output logic                core_data_get,
    output logic                core_stall
);
    localparam int CNT_W = HOLD_LIMIT > 0 ? $clog2(HOLD_LIMIT + 1) : 1;

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t              state;
    logic [IDX_BITS-1:0] rr_ptr;
    logic [IDX_BITS-1:0] win_idx;
    logic [CNT_W-1:0]    idle_cnt;
    logic [NUM_EP-1:0]   cand;
    logic                found;
    logic                held;
    logic                preempt;
    int                  j;

    assign grant_valid   = |ep_grant;
    assign core_data_get = grant_valid & ep_data_get[grant_idx];
    assign core_stall    = grant_valid & ep_stall[grant_idx];
    assign held          = state == GRANTED && ep_req[grant_idx];

    // The current grantee is masked out so a preemption always hands over to someone else.
    always_comb begin
        cand    = ep_req & ~ep_grant;
        found   = 1'b0;
        win_idx = '0;
        j       = 0;
        for (int i = 0; i < NUM_EP; i++) begin
            j = int'(rr_ptr) + i;
            j = j >= NUM_EP ? j - NUM_EP : j;
            if (!found && cand[j[IDX_BITS-1:0]]) begin
                found   = 1'b1;
                win_idx = j[IDX_BITS-1:0];
            end
        end
        preempt = HOLD_LIMIT > 0 && held && !ep_data_get[grant_idx] && found &&
                  int'(idle_cnt) >= HOLD_LIMIT - 1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ep_grant  <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
            idle_cnt  <= '0;
        end else if (!held || preempt) begin
            idle_cnt <= '0;
            if (found) begin
                state     <= GRANTED;
                ep_grant  <= NUM_EP'(1) << win_idx;
                grant_idx <= win_idx;
                rr_ptr    <= win_idx == IDX_BITS'(NUM_EP - 1) ? '0 : win_idx + 1'b1;
            end else begin
                state     <= IDLE;
                ep_grant  <= '0;
                grant_idx <= '0;
            end
        end else begin
            idle_cnt <= ep_data_get[grant_idx] ? '0 :
                        int'(idle_cnt) < HOLD_LIMIT ? idle_cnt + 1'b1 : idle_cnt;
        end
    end
endmodule

// File: tb/tb_usb_out_ep_arbiter.sv
// tb_usb_out_ep_arbiter: directed checks of grant order, isolation, preemption, reset and
// non-power-of-two wrap, using a 4-client preempting instance and a 3-client instance.
module tb_usb_out_ep_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0, dg = '0, st = '0, grant;
    logic       gv, cdg, cst;
    logic [1:0] gidx;
    logic [2:0] req3 = '0, dg3 = '0, st3 = '0, grant3;
    logic       gv3, cdg3, cst3;
    logic [1:0] gidx3;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    usb_out_ep_arbiter #(.NUM_EP(4), .HOLD_LIMIT(8)) dut (
        .clk(clk), .reset(rst_n), .ep_req(req), .ep_data_get(dg), .ep_stall(st),
        .ep_grant(grant), .grant_valid(gv), .grant_idx(gidx),
        .core_data_get(cdg), .core_stall(cst)
    );

    usb_out_ep_arbiter #(.NUM_EP(3), .HOLD_LIMIT(0)) dut3 (
        .clk(clk), .reset(rst_n), .ep_req(req3), .ep_data_get(dg3), .ep_stall(st3),
        .ep_grant(grant3), .grant_valid(gv3), .grant_idx(gidx3),
        .core_data_get(cdg3), .core_stall(cst3)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req = '0; dg = '0; st = '0; req3 = '0; dg3 = '0; st3 = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = 4'b0100; dg = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (grant !== 4'b0000 || gv !== 1'b0 || cdg !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold: grant=%b gv=%b cdg=%b, want 0000/0/0", grant, gv, cdg);
            end
        end
        rst_n = 1'b1;
        step();
        tests++;
        if (grant !== 4'b0100 || gidx !== 2'd2 || gv !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_grant: grant=%b idx=%0d gv=%b, want 0100/2/1", grant, gidx, gv);
        end
        tests++;
        if (cdg !== 1'b1) begin
            fails++;
            $display("FAIL reset_data_follow: cdg=%b, want 1", cdg);
        end
        dg = 4'b1011;
        #1;
        tests++;
        if (cdg !== 1'b0) begin
            fails++;
            $display("FAIL reset_data_other: cdg=%b, want 0", cdg);
        end
        req = '0; dg = '0;
        step();
        tests++;
        if (grant !== 4'b0000 || gidx !== 2'd0) begin
            fails++;
            $display("FAIL reset_release: grant=%b idx=%0d, want 0000/0", grant, gidx);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp;
        do_reset();
        req = 4'b1111;
        step();
        tests++;
        if (grant !== 4'b0001 || gidx !== 2'd0) begin
            fails++;
            $display("FAIL rr_first: grant=%b idx=%0d, want 0001/0", grant, gidx);
        end
        for (int k = 0; k < 4; k++) begin
            dg = 4'(1 << k);
            for (int c = 0; c < 3; c++) step();
            tests++;
            if (grant !== 4'(1 << k)) begin
                fails++;
                $display("FAIL rr_hold_%0d: grant=%b, want %b", k, grant, 4'(1 << k));
            end
            dg = '0;
            req = 4'b1111 & ~4'(1 << k);
            step();
            req = 4'b1111;
            exp = 4'(1 << ((k + 1) % 4));
            tests++;
            if (grant !== exp || gidx !== 2'((k + 1) % 4)) begin
                fails++;
                $display("FAIL rr_next_%0d: grant=%b idx=%0d, want %b/%0d", k, grant, gidx, exp, (k + 1) % 4);
            end
        end
    endtask

    task automatic test_isolation;
        do_reset();
        req = 4'b0010;
        step();
        tests++;
        if (grant !== 4'b0010 || gidx !== 2'd1) begin
            fails++;
            $display("FAIL iso_grant: grant=%b idx=%0d, want 0010/1", grant, gidx);
        end
        dg = 4'b0001; st = 4'b1000;
        #1;
        tests++;
        if (cdg !== 1'b0 || cst !== 1'b0) begin
            fails++;
            $display("FAIL iso_ignore: cdg=%b cst=%b, want 0/0", cdg, cst);
        end
        dg = '0; st = 4'b0010;
        #1;
        tests++;
        if (cst !== 1'b1 || cdg !== 1'b0) begin
            fails++;
            $display("FAIL iso_stall: cst=%b cdg=%b, want 1/0", cst, cdg);
        end
        st = '0; req = '0;
        step();
    endtask

    task automatic test_preempt;
        logic bad;
        do_reset();
        req = 4'b0001;
        step();
        bad = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            if (e == 4) req = 4'b0101;
            step();
            if (grant !== 4'b0001) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL pre_early: grant moved before limit, now %b, want 0001", grant);
        end
        step();
        tests++;
        if (grant !== 4'b0100 || gidx !== 2'd2) begin
            fails++;
            $display("FAIL pre_move: grant=%b idx=%0d, want 0100/2", grant, gidx);
        end
        dg = 4'b0100;
        req = 4'b0001;
        step();
        dg = '0;
        tests++;
        if (grant !== 4'b0001) begin
            fails++;
            $display("FAIL pre_pending: grant=%b, want 0001", grant);
        end
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0101;
        bad = 1'b0;
        for (int i = 0; i < 28; i++) begin
            dg = (i % 7 == 6) ? 4'b0001 : 4'b0000;
            step();
            if (grant !== 4'b0001) bad = 1'b1;
        end
        dg = '0;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL pre_strobed: preempted despite strobes, grant=%b, want 0001", grant);
        end
        for (int i = 0; i < 7; i++) step();
        dg = 4'b0001;
        step();
        dg = '0;
        tests++;
        if (grant !== 4'b0001) begin
            fails++;
            $display("FAIL pre_get_blocks: grant=%b, want 0001", grant);
        end
        req = '0;
        step();
    endtask

    task automatic test_mid_reset;
        do_reset();
        req = 4'b1000;
        step();
        tests++;
        if (grant !== 4'b1000 || gidx !== 2'd3) begin
            fails++;
            $display("FAIL mr_grant: grant=%b idx=%0d, want 1000/3", grant, gidx);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (grant !== 4'b0000 || gv !== 1'b0 || gidx !== 2'd0 || cst !== 1'b0) begin
            fails++;
            $display("FAIL mr_async: grant=%b gv=%b idx=%0d, want 0000/0/0", grant, gv, gidx);
        end
        req = 4'b1010;
        step();
        tests++;
        if (grant !== 4'b0000) begin
            fails++;
            $display("FAIL mr_held: grant=%b, want 0000", grant);
        end
        rst_n = 1'b1;
        step();
        tests++;
        if (grant !== 4'b0010 || gidx !== 2'd1) begin
            fails++;
            $display("FAIL mr_restart: grant=%b idx=%0d, want 0010/1", grant, gidx);
        end
        req = '0;
        step();
    endtask

    task automatic test_wrap3;
        logic [2:0] exp;
        logic bad;
        do_reset();
        req3 = 3'b111;
        step();
        tests++;
        if (grant3 !== 3'b001 || gidx3 !== 2'd0) begin
            fails++;
            $display("FAIL w3_first: grant=%b idx=%0d, want 001/0", grant3, gidx3);
        end
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req3 = 3'b111 & ~3'(1 << (k % 3));
            step();
            req3 = 3'b111;
            exp = 3'(1 << ((k + 1) % 3));
            if (gidx3 == 2'd3) bad = 1'b1;
            tests++;
            if (grant3 !== exp || gidx3 !== 2'((k + 1) % 3)) begin
                fails++;
                $display("FAIL w3_next_%0d: grant=%b idx=%0d, want %b/%0d", k, grant3, gidx3, exp, (k + 1) % 3);
            end
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL w3_idx_range: grant_idx reached 3, want 0..2");
        end
        req3 = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_isolation();
        test_preempt();
        test_mid_reset();
        test_wrap3();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
